// File: rtl/iob_eth_rx.sv
// iob_eth_rx: MII receive engine. Strips preamble/SFD, packs nibbles into
// bytes (low nibble first), writes every post-SFD byte to the RX buffer from
// address 0, checks CRC-32 inline and holds a frame-received status until
// the host acknowledges it.
// Optional build macro ETH_RX_MAC_FILTER_EN: drop frames whose destination
// MAC is neither mac_addr nor broadcast.
module iob_eth_rx #(
  parameter  int BUF_ADDR_W = 11,
  localparam int DATA_W     = 8
) (
  input  logic                  RX_CLK,
  input  logic                  rst,
  input  logic                  RX_DV,
  input  logic [3:0]            RX_DATA,
  input  logic [47:0]           mac_addr,
  output logic [BUF_ADDR_W-1:0] addr,
  output logic [DATA_W-1:0]     data,
  output logic                  wr,
  output logic [BUF_ADDR_W:0]   nbytes,
  output logic                  rcvd,
  output logic                  crc_err,
  input  logic                  rcv_ack,
  output logic [7:0]            drop_cnt
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  // Shortest legal frame after SFD (dest + src + len + FCS).
  localparam logic [BUF_ADDR_W:0] MIN_LEN = (BUF_ADDR_W+1)'(18);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DONE,
    S_DROP
  } state_t;

  state_t                r_state;
  logic                  r_phase;     // 0: expecting low nibble, 1: high nibble
  logic [3:0]            r_nib;
  logic [BUF_ADDR_W:0]   r_count;
  logic [31:0]           r_crc;
  logic [BUF_ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0]     r_data;
  logic                  r_wr;
  logic [BUF_ADDR_W:0]   r_nbytes;
  logic                  r_rcvd;
  logic                  r_crc_err;
  logic [7:0]            r_drop_cnt;

  logic [7:0]  w_byte;
  logic [31:0] w_crc_next;
  logic [7:0]  w_drop_inc;
  logic        w_full;
  logic        w_byte_wr;
  logic        w_filt_drop;

  // Reflected CRC-32, one nibble at a time, LSB first.
  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] n);
    logic [31:0] x;
    x = c;
    for (int b = 0; b < 4; b++) begin
      x = (x[0] ^ n[b]) ? ((x >> 1) ^ CRC_POLY) : (x >> 1);
    end
    return x;
  endfunction

  assign w_byte     = {RX_DATA, r_nib};
  assign w_crc_next = crc_nib(r_crc, RX_DATA);
  assign w_drop_inc = (r_drop_cnt == 8'hFF) ? r_drop_cnt : r_drop_cnt + 8'd1;
  // Count has reached buffer size: the next byte has nowhere to go.
  assign w_full     = r_count[BUF_ADDR_W];
  assign w_byte_wr  = (r_state == S_DATA) && !w_filt_drop && RX_DV && r_phase && !w_full;

`ifdef ETH_RX_MAC_FILTER_EN
  logic [47:0] r_dest;
  logic        r_chk;

  // Shift dest bytes in from the top so byte k lands at [8k+7:8k]; flag the
  // cycle after dest byte 5 so the comparison sees all six bytes.
  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      r_dest <= 48'd0;
      r_chk  <= 1'b0;
    end else begin
      r_chk <= w_byte_wr && (r_count == (BUF_ADDR_W+1)'(5));
      if (w_byte_wr && (r_count < (BUF_ADDR_W+1)'(6))) begin
        r_dest <= {w_byte, r_dest[47:8]};
      end
    end
  end

  assign w_filt_drop = r_chk && (r_dest != mac_addr) && (r_dest != 48'hFFFF_FFFF_FFFF);
`else
  logic w_unused_mac;
  assign w_unused_mac = ^mac_addr;
  assign w_filt_drop  = 1'b0;
`endif

  // Receive state machine with registered buffer-write and status outputs.
  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_phase    <= 1'b0;
      r_nib      <= 4'd0;
      r_count    <= '0;
      r_crc      <= 32'hFFFF_FFFF;
      r_addr     <= '0;
      r_data     <= '0;
      r_wr       <= 1'b0;
      r_nbytes   <= '0;
      r_rcvd     <= 1'b0;
      r_crc_err  <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      r_wr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (RX_DV) begin
            if (RX_DATA == 4'h5) begin
              r_state <= S_PREAMBLE;
            end else begin
              r_state    <= S_DROP;
              r_drop_cnt <= w_drop_inc;
            end
          end
        end
        S_PREAMBLE: begin
          if (!RX_DV) begin
            r_state <= S_IDLE;
          end else if (RX_DATA == 4'hD) begin
            r_state <= S_DATA;
            r_phase <= 1'b0;
            r_count <= '0;
            r_crc   <= 32'hFFFF_FFFF;
          end else if (RX_DATA != 4'h5) begin
            r_state    <= S_DROP;
            r_drop_cnt <= w_drop_inc;
          end
        end
        S_DATA: begin
          if (w_filt_drop) begin
            r_state    <= S_DROP;
            r_drop_cnt <= w_drop_inc;
          end else if (!RX_DV) begin
            // A dangling low nibble (dribble) or short frame is an error too.
            r_nbytes  <= r_count;
            r_rcvd    <= 1'b1;
            r_crc_err <= (r_crc != CRC_RESIDUE) || (r_count < MIN_LEN) || r_phase;
            r_state   <= S_DONE;
          end else if (!r_phase) begin
            r_nib   <= RX_DATA;
            r_phase <= 1'b1;
            r_crc   <= w_crc_next;
          end else if (w_full) begin
            r_state    <= S_DROP;
            r_drop_cnt <= w_drop_inc;
          end else begin
            r_wr    <= 1'b1;
            r_addr  <= r_count[BUF_ADDR_W-1:0];
            r_data  <= w_byte;
            r_count <= r_count + 1'b1;
            r_crc   <= w_crc_next;
            r_phase <= 1'b0;
          end
        end
        S_DONE: begin
          if (rcv_ack) begin
            r_rcvd    <= 1'b0;
            r_crc_err <= 1'b0;
            if (RX_DV) begin
              // A frame that began while the status was held is lost.
              r_state    <= S_DROP;
              r_drop_cnt <= w_drop_inc;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (!RX_DV) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign addr     = r_addr;
  assign data     = r_data;
  assign wr       = r_wr;
  assign nbytes   = r_nbytes;
  assign rcvd     = r_rcvd;
  assign crc_err  = r_crc_err;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_iob_eth_rx.sv
// Scoreboard bench for iob_eth_rx (BUF_ADDR_W=6 so overflow is reachable).
module tb_iob_eth_rx;
  localparam int AW = 6;

  logic          RX_CLK = 1'b0;
  logic          rst;
  logic          RX_DV;
  logic [3:0]    RX_DATA;
  logic [47:0]   mac_addr;
  logic [AW-1:0] addr;
  logic [7:0]    data;
  logic          wr;
  logic [AW:0]   nbytes;
  logic          rcvd;
  logic          crc_err;
  logic          rcv_ack;
  logic [7:0]    drop_cnt;

  iob_eth_rx #(.BUF_ADDR_W(AW)) dut (
    .RX_CLK(RX_CLK), .rst(rst), .RX_DV(RX_DV), .RX_DATA(RX_DATA),
    .mac_addr(mac_addr), .addr(addr), .data(data), .wr(wr),
    .nbytes(nbytes), .rcvd(rcvd), .crc_err(crc_err), .rcv_ack(rcv_ack),
    .drop_cnt(drop_cnt)
  );

  always #5 RX_CLK = ~RX_CLK;

  typedef struct { logic [AW-1:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic [AW:0] n; logic e; } st_t;

  wr_t        wq[$];
  st_t        sq[$];
  logic [7:0] fr[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         exp_drop = 0;
  logic       rcvd_q = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  // Bytewise reference CRC-32 over the frame body; returns the FCS value.
  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, fr[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // n = total bytes after SFD including 4-byte FCS.
  task automatic build(input int n, input logic [47:0] dst, input logic [7:0] seed);
    logic [31:0] f;
    fr.delete();
    for (int i = 0; i < n - 4; i++) begin
      if (i < 6)       fr.push_back(dst[8*i +: 8]);
      else if (i < 12) fr.push_back(8'h02 + 8'(i));
      else             fr.push_back(seed + 8'(i * 13));
    end
    f = fcs_of(n - 4);
    for (int k = 0; k < 4; k++) fr.push_back(f[8*k +: 8]);
  endtask

  task automatic drv(input logic dv, input logic [3:0] n);
    @(posedge RX_CLK); #1;
    RX_DV = dv;
    RX_DATA = n;
  endtask

  task automatic tx_frame(input int wr_limit, input bit dribble, input logic [3:0] first_nib);
    drv(1'b1, first_nib);
    repeat (14) drv(1'b1, 4'h5);
    drv(1'b1, 4'hD);
    for (int i = 0; i < fr.size(); i++) begin
      if (i < wr_limit) wq.push_back('{a: AW'(i), d: fr[i]});
      drv(1'b1, fr[i][3:0]);
      drv(1'b1, fr[i][7:4]);
    end
    if (dribble) drv(1'b1, 4'h7);
    repeat (6) drv(1'b0, 4'h0);
  endtask

  task automatic exp_status(input int n, input logic e);
    sq.push_back('{n: (AW+1)'(n), e: e});
  endtask

  task automatic ack_and_check();
    @(negedge RX_CLK);
    chk("rcvd_set", 64'(rcvd), 64'd1);
    @(posedge RX_CLK); #1 rcv_ack = 1'b1;
    @(posedge RX_CLK); #1 rcv_ack = 1'b0;
    @(negedge RX_CLK);
    chk("rcvd_clr", 64'(rcvd), 64'd0);
    chk("crc_err_clr", 64'(crc_err), 64'd0);
  endtask

  // Monitor: pops expected writes and status as the DUT presents them.
  initial begin
    wr_t we;
    st_t se;
    forever begin
      @(negedge RX_CLK);
      if (rst) begin
        rcvd_q = 1'b0;
      end else begin
        if (wr) begin
          if (wq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL wr_unexpected: addr=%0d data=%02h, required no write", addr, data);
          end else begin
            we = wq.pop_front();
            chk("wr_addr_data", 64'({addr, data}), 64'({we.a, we.d}));
          end
        end
        if (rcvd && !rcvd_q) begin
          if (sq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL rcvd_unexpected: nbytes=%0d, required no rcvd", nbytes);
          end else begin
            se = sq.pop_front();
            chk("nbytes", 64'(nbytes), 64'(se.n));
            chk("crc_err", 64'(crc_err), 64'(se.e));
          end
        end
        rcvd_q = rcvd;
      end
    end
  end

  initial begin
    rst = 1'b1; RX_DV = 1'b0; RX_DATA = 4'h0; rcv_ack = 1'b0;
    mac_addr = 48'h0A0B0C0D0E0F;
    repeat (3) @(posedge RX_CLK);
    @(negedge RX_CLK);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_wr", 64'(wr), 64'd0);
    chk("rst_nbytes", 64'(nbytes), 64'd0);
    chk("rst_rcvd", 64'(rcvd), 64'd0);
    chk("rst_crc_err", 64'(crc_err), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(posedge RX_CLK); #1 rst = 1'b0;

    // 1: good 64-byte frame
    build(64, mac_addr, 8'h10);
    exp_status(64, 1'b0);
    tx_frame(64, 1'b0, 4'h5);
    ack_and_check();

    // 2: payload byte 20 corrupted
    build(64, mac_addr, 8'h10);
    fr[20] = fr[20] ^ 8'h01;
    exp_status(64, 1'b1);
    tx_frame(64, 1'b0, 4'h5);
    ack_and_check();

    // 3: dribble nibble, then runt with good CRC
    build(64, mac_addr, 8'h55);
    exp_status(64, 1'b1);
    tx_frame(64, 1'b1, 4'h5);
    ack_and_check();
    build(10, mac_addr, 8'h00);
    exp_status(10, 1'b1);
    tx_frame(10, 1'b0, 4'h5);
    ack_and_check();

    // 4: overflow beyond 64 bytes, then bad first nibble
    build(80, mac_addr, 8'h3C);
    exp_drop++;
    tx_frame(64, 1'b0, 4'h5);
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    chk("ovf_no_rcvd", 64'(rcvd), 64'd0);
    chk("ovf_nbytes_kept", 64'(nbytes), 64'd10);
    build(64, mac_addr, 8'h10);
    exp_drop++;
    tx_frame(0, 1'b0, 4'h3);
    chk("bad_pre_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    chk("bad_pre_no_rcvd", 64'(rcvd), 64'd0);

    // 5: frame arrives while status held; ack lands mid-frame
    build(64, mac_addr, 8'h21);
    exp_status(64, 1'b0);
    tx_frame(64, 1'b0, 4'h5);
    build(20, mac_addr, 8'h33);
    fork
      tx_frame(0, 1'b0, 4'h5);
      begin
        repeat (34) @(posedge RX_CLK);
        #1 rcv_ack = 1'b1;
        @(posedge RX_CLK); #1 rcv_ack = 1'b0;
      end
    join
    exp_drop++;
    chk("held_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    chk("held_rcvd_clr", 64'(rcvd), 64'd0);
    chk("held_nbytes_kept", 64'(nbytes), 64'd64);
    build(40, mac_addr, 8'h44);
    exp_status(40, 1'b0);
    tx_frame(40, 1'b0, 4'h5);
    ack_and_check();

    // 6: destination filtering
    build(64, 48'h0A0B0C0D0E0F, 8'h61);
    exp_status(64, 1'b0);
    tx_frame(64, 1'b0, 4'h5);
    ack_and_check();
    build(64, 48'hFFFFFFFFFFFF, 8'h62);
    exp_status(64, 1'b0);
    tx_frame(64, 1'b0, 4'h5);
    ack_and_check();
    build(64, 48'h060504030201, 8'h63);
`ifdef ETH_RX_MAC_FILTER_EN
    exp_drop++;
    tx_frame(6, 1'b0, 4'h5);
    chk("filt_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    chk("filt_no_rcvd", 64'(rcvd), 64'd0);
`else
    exp_status(64, 1'b0);
    tx_frame(64, 1'b0, 4'h5);
    ack_and_check();
    chk("nofilt_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
`endif

    // 6b: reset at byte 30; remainder of frame absorbed as one drop
    fr.delete();
    repeat (64) fr.push_back(8'h11);
    drv(1'b1, 4'h5);
    repeat (14) drv(1'b1, 4'h5);
    drv(1'b1, 4'hD);
    for (int i = 0; i < 30; i++) begin
      wq.push_back('{a: AW'(i), d: fr[i]});
      drv(1'b1, fr[i][3:0]);
      drv(1'b1, fr[i][7:4]);
    end
    drv(1'b1, 4'h1);
    @(posedge RX_CLK); #1 rst = 1'b1; RX_DATA = 4'h1;
    @(negedge RX_CLK);
    chk("mid_rst_addr", 64'(addr), 64'd0);
    chk("mid_rst_data", 64'(data), 64'd0);
    chk("mid_rst_wr", 64'(wr), 64'd0);
    chk("mid_rst_nbytes", 64'(nbytes), 64'd0);
    chk("mid_rst_rcvd", 64'(rcvd), 64'd0);
    chk("mid_rst_crc_err", 64'(crc_err), 64'd0);
    chk("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(posedge RX_CLK); #1 rst = 1'b0;
    exp_drop = 1;
    for (int i = 31; i < 64; i++) begin
      drv(1'b1, 4'h1);
      drv(1'b1, 4'h1);
    end
    repeat (6) drv(1'b0, 4'h0);
    chk("post_rst_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    chk("post_rst_no_rcvd", 64'(rcvd), 64'd0);

    repeat (10) @(posedge RX_CLK);
    chk("writes_all_seen", 64'(wq.size()), 64'd0);
    chk("status_all_seen", 64'(sq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule
